// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (if_*) and
// load/store data (d_*). One transaction is outstanding at a time. Data has
// fixed priority over fetch, but after MAX_D_STREAK consecutive data grants
// taken while a fetch was pending, the next contended grant goes to fetch.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES mem_req cycles without mem_ack; the owner then sees rvalid
// with err = 1 and rdata = 0. Without the macro, WAIT never times out and the
// err outputs are tied to 0.
//
// Ports:
//   clk_i, reset_i          clock (rising edge), synchronous active-high reset
//   if_req_i, if_addr_i     fetch request/address, req held until if_gnt_o
//   if_gnt_o                fetch accepted (combinational, IDLE only)
//   if_rvalid_o/_rdata_o/_err_o  fetch response strobe, data, error
//   d_req_i, d_we_i, d_addr_i, d_wdata_i, d_be_i  data request, held until d_gnt_o
//   d_gnt_o                 data accepted (combinational, IDLE only)
//   d_rvalid_o/_rdata_o/_err_o   data response strobe, load data (0 on writes), error
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o  registered memory request
//   mem_ack_i, mem_rdata_i  memory completion strobe and read data
module mem_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MAX_D_STREAK   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_err_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                d_err_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int unsigned BeW     = DATA_W / 8;
    localparam int unsigned StreakW = $clog2(MAX_D_STREAK + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_D_STREAK);

    // Illegal configurations land in this block; it is empty so that the check
    // is visible to elaboration without adding any logic.
    if (MAX_D_STREAK < 1 || TIMEOUT_CYCLES < 1 || (DATA_W % 8) != 0) begin : g_bad_params
    end

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e              state_q, state_d;
    logic [StreakW-1:0]  streak_q, streak_d;
    logic                owner_q;  // 1 = data owns the outstanding transaction
    logic                if_gnt, d_gnt;
    logic                ack_done;
    logic                tmo_done;

    logic                mem_req_q, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [BeW-1:0]      mem_be_q;
    logic                if_rvalid_q, d_rvalid_q;
    logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;

    assign ack_done = (state_q == StWait) && mem_ack_i;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (if_gnt || d_gnt) state_d = StWait;
            StWait: if (ack_done || tmo_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Grant selection: data first unless the streak guard has tripped while
    // a fetch is waiting.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (state_q == StIdle) begin
            if (d_req_i && !(if_req_i && (streak_q == StreakMax))) begin
                d_gnt = 1'b1;
            end else if (if_req_i) begin
                if_gnt = 1'b1;
            end
        end
    end

    assign if_gnt_o = if_gnt;
    assign d_gnt_o  = d_gnt;

    // ------------------------------------------------------ streak counter
    always_comb begin
        streak_d = streak_q;
        if (d_gnt) begin
            if (!if_req_i) begin
                streak_d = '0;
            end else if (streak_q != StreakMax) begin
                streak_d = streak_q + 1'b1;
            end
        end else if (if_gnt) begin
            streak_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    // --------------------------------------------------- request/response
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            owner_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if (d_gnt) begin
                owner_q     <= 1'b1;
                mem_req_q   <= 1'b1;
                mem_we_q    <= d_we_i;
                mem_addr_q  <= d_addr_i;
                mem_wdata_q <= d_wdata_i;
                mem_be_q    <= d_be_i;
            end else if (if_gnt) begin
                owner_q     <= 1'b0;
                mem_req_q   <= 1'b1;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= if_addr_i;
                mem_wdata_q <= '0;
                mem_be_q    <= '1;
            end
            if (ack_done) begin
                mem_req_q <= 1'b0;
                if (owner_q) begin
                    d_rvalid_q <= 1'b1;
                    d_rdata_q  <= mem_we_q ? '0 : mem_rdata_i;
                end else begin
                    if_rvalid_q <= 1'b1;
                    if_rdata_q  <= mem_rdata_i;
                end
            end else if (tmo_done) begin
                mem_req_q <= 1'b0;
                if (owner_q) begin
                    d_rvalid_q <= 1'b1;
                    d_rdata_q  <= '0;
                end else begin
                    if_rvalid_q <= 1'b1;
                    if_rdata_q  <= '0;
                end
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            if_err_q, d_err_q;

    // tmo_q counts completed mem_req cycles; the last allowed cycle has
    // tmo_q == TIMEOUT_CYCLES-1. An ack in that cycle still completes normally.
    assign tmo_done = (state_q == StWait) && !mem_ack_i && (tmo_q == TmoLast);

    always_comb begin
        tmo_d = tmo_q;
        if (if_gnt || d_gnt) begin
            tmo_d = '0;
        end else if (state_q == StWait) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tmo_q    <= '0;
            if_err_q <= 1'b0;
            d_err_q  <= 1'b0;
        end else begin
            tmo_q    <= tmo_d;
            if_err_q <= tmo_done && !owner_q;
            d_err_q  <= tmo_done && owner_q;
        end
    end

    assign if_err_o = if_err_q;
    assign d_err_o  = d_err_q;
`else
    assign tmo_done = 1'b0;
    assign if_err_o = 1'b0;
    assign d_err_o  = 1'b0;
`endif

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_be_o    = mem_be_q;
    assign if_rvalid_o = if_rvalid_q;
    assign d_rvalid_o  = d_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of single transactions plus
// hand-written sequences for contention, reset in WAIT, spurious ack and the
// optional timeout.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .MAX_D_STREAK   (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_gnt_o    (if_gnt),
        .if_rvalid_o (if_rvalid),
        .if_rdata_o  (if_rdata),
        .if_err_o    (if_err),
        .d_req_i     (d_req),
        .d_we_i      (d_we),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_be_i      (d_be),
        .d_gnt_o     (d_gnt),
        .d_rvalid_o  (d_rvalid),
        .d_rdata_o   (d_rdata),
        .d_err_o     (d_err),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_be_o    (mem_be),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata)
    );

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          ack_lat;    // mem_req cycle (1-based) in which mem_ack is given
        logic [31:0] mem_rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        if (v.is_data) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        @(negedge clk);
        check("gnt_if", {31'b0, if_gnt}, {31'b0, ~v.is_data});
        check("gnt_d", {31'b0, d_gnt}, {31'b0, v.is_data});
        check("req_before", {31'b0, mem_req}, 32'd0);
        step();
        if_req = 1'b0;
        d_req  = 1'b0;
        for (int k = 1; k <= v.ack_lat; k++) begin
            // The other requester asks during WAIT and must not be granted.
            if (v.is_data) if_req = 1'b1;
            else d_req = 1'b1;
            if (k == v.ack_lat) begin
                mem_ack = 1'b1;
                mem_rdata = v.mem_rdata;
            end
            @(negedge clk);
            check("wait_req", {31'b0, mem_req}, 32'd1);
            check("wait_addr", mem_addr, v.addr);
            check("wait_we", {31'b0, mem_we}, {31'b0, v.is_data & v.we});
            check("wait_be", {28'b0, mem_be}, {28'b0, v.exp_be});
            if (v.is_data && v.we) check("wait_wdata", mem_wdata, v.wdata);
            check("wait_no_gnt", {30'b0, if_gnt, d_gnt}, 32'd0);
            check("wait_no_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'd0);
            step();
            mem_ack = 1'b0;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
        check("rvalid_if", {31'b0, if_rvalid}, {31'b0, ~v.is_data});
        check("rvalid_d", {31'b0, d_rvalid}, {31'b0, v.is_data});
        check("rdata", v.is_data ? d_rdata : if_rdata, v.exp_rdata);
        check("err", {30'b0, if_err, d_err}, 32'd0);
        check("req_after", {31'b0, mem_req}, 32'd0);
        step();
        @(negedge clk);
        check("rvalid_pulse", {30'b0, if_rvalid, d_rvalid}, 32'd0);
        check("rdata_hold", v.is_data ? d_rdata : if_rdata, v.exp_rdata);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_order [10];
        int   got;
        int   cnt;
        logic seen;

        //           is_data we  addr          wdata         be    lat mem_rdata     exp_be exp_rdata
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'h0, 1, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3, 3, 32'hAAAA_5555, 4'h3, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,        4'hF, 2, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,        4'h0, 4, 32'h0123_4567, 4'hF, 32'h0123_4567};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0308, 32'h0,        4'h8, 1, 32'h8000_0001, 4'h8, 32'h8000_0001};
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        step();
        step();
        @(negedge clk);
        check("reset_mem", {mem_req, mem_we, mem_be, 26'b0} | mem_addr | mem_wdata, 32'd0);
        check("reset_resp", {28'b0, if_rvalid, d_rvalid, if_err, d_err} | if_rdata | d_rdata, 32'd0);
        check("reset_gnt", {30'b0, if_gnt, d_gnt}, 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("idle_no_gnt", {30'b0, if_gnt, d_gnt}, 32'd0);
        step();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Contention with an immediately-acking memory.
        if_req = 1'b1; if_addr = 32'h0000_0400;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0800; d_be = 4'hF;
        got = 0;
        for (int c = 0; c < 200 && got < 10; c++) begin
            mem_ack = mem_req;
            mem_rdata = 32'(c);
            @(negedge clk);
            check("gnt_exclusive", {31'b0, if_gnt & d_gnt}, 32'd0);
            check("rvalid_exclusive", {31'b0, if_rvalid & d_rvalid}, 32'd0);
            if (if_gnt || d_gnt) begin
                check($sformatf("order_%0d", got), {31'b0, d_gnt}, {31'b0, exp_order[got]});
                got++;
            end
            step();
        end
        check("contention_grants", got, 32'd10);
        if_req = 1'b0;
        d_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            mem_ack = mem_req;
            step();
        end
        mem_ack = 1'b0;
        @(negedge clk);
        check("contention_drained", {31'b0, mem_req}, 32'd0);
        step();

        // Reset two cycles after d_gnt, ack arriving one cycle later.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0C00; d_be = 4'hF;
        @(negedge clk);
        check("rst_wait_gnt", {31'b0, d_gnt}, 32'd1);
        step();
        d_req = 1'b0;
        @(negedge clk);
        check("rst_wait_req", {31'b0, mem_req}, 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        check("rst_wait_mem", {mem_req, mem_we, mem_be, 26'b0} | mem_addr | mem_wdata, 32'd0);
        check("rst_wait_resp", {28'b0, if_rvalid, d_rvalid, if_err, d_err} | if_rdata | d_rdata,
              32'd0);
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        check("rst_late_ack", {29'b0, mem_req, if_rvalid, d_rvalid}, 32'd0);
        step();
        run_vec(vecs[0]);

        // Spurious ack in IDLE.
        mem_ack = 1'b1;
        mem_rdata = 32'h7777_7777;
        @(negedge clk);
        check("spur_req", {31'b0, mem_req}, 32'd0);
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        check("spur_rvalid", {29'b0, mem_req, if_rvalid, d_rvalid}, 32'd0);
        check("spur_rdata", if_rdata, 32'hDEAD_BEEF);
        step();
        run_vec(vecs[2]);

`ifdef MEM_ARB_TIMEOUT_EN
        // Fetch that memory never acknowledges.
        if_req = 1'b1; if_addr = 32'h0000_0500;
        @(negedge clk);
        check("tmo_gnt", {31'b0, if_gnt}, 32'd1);
        step();
        if_req = 1'b0;
        cnt = 0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (mem_req) cnt++;
            if (if_rvalid) begin
                seen = 1'b1;
                check("tmo_err", {31'b0, if_err}, 32'd1);
                check("tmo_rdata", if_rdata, 32'd0);
                check("tmo_d_rvalid", {31'b0, d_rvalid}, 32'd0);
            end
            step();
        end
        check("tmo_seen", {31'b0, seen}, 32'd1);
        check("tmo_req_cycles", cnt, 32'd8);
        @(negedge clk);
        check("tmo_err_pulse", {30'b0, if_err, if_rvalid}, 32'd0);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
